// File: rtl/writeback_scheduler.sv
// rtl/writeback_scheduler.sv - register-file write port arbiter with a 2-entry late-result FIFO
// Optional feature macro: WB_HAZARD_CHECK_EN (write-after-write ordering against queued late results)
module writeback_scheduler #(
   parameter int DATA_WIDTH = 16,
   parameter int NREG_BITS  = 3,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  pri_valid_i,
   input  logic [2:0]            pri_sel_i,
   input  logic [NREG_BITS-1:0]  pri_dest_i,
   input  logic                  late_valid_i,
   output logic                  late_ready_o,
   input  logic [NREG_BITS-1:0]  late_dest_i,
   input  logic [DATA_WIDTH-1:0] late_data_i,
   output logic [2:0]            selection_o,
   output logic [DATA_WIDTH-1:0] late_out_o,
   output logic                  reg_write_o,
   output logic [NREG_BITS-1:0]  reg_dest_o,
   output logic                  stall_o,
   output logic [1:0]            pending_o
);

   localparam logic [2:0] SEL_LATE = 3'd7;
   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   logic [1:0][NREG_BITS-1:0]  dest_q, dest_d;
   logic [1:0][DATA_WIDTH-1:0] data_q, data_d;
   logic                       head_q, head_d;
   logic [1:0]                 count_q, count_d;
   logic [3:0]                 wait_q, wait_d;

   logic pri_req;
   logic hazard;
   logic late_grant;
   logic push;
   logic tail;

   // Grant decision and write-port outputs; everything forced idle while reset is high.
   always_comb begin
      pri_req      = pri_valid_i && (pri_sel_i != SEL_LATE);
      hazard       = 1'b0;
`ifdef WB_HAZARD_CHECK_EN
      if (pri_req) begin
         if ((count_q != 2'd0) && (dest_q[head_q] == pri_dest_i)) hazard = 1'b1;
         if ((count_q == 2'd2) && (dest_q[~head_q] == pri_dest_i)) hazard = 1'b1;
      end
`endif
      late_grant   = !reset_i && (count_q != 2'd0) &&
                     (!pri_req || (wait_q == WAIT_MAX) || hazard);
      late_ready_o = !reset_i && (count_q < 2'd2);
      push         = late_valid_i && late_ready_o;
      tail         = head_q ^ count_q[0];

      selection_o  = 3'd0;
      reg_dest_o   = '0;
      reg_write_o  = 1'b0;
      stall_o      = 1'b0;
      if (late_grant) begin
         selection_o = SEL_LATE;
         reg_dest_o  = dest_q[head_q];
         reg_write_o = 1'b1;
         stall_o     = pri_req;
      end else if (!reset_i && pri_req) begin
         selection_o = pri_sel_i;
         reg_dest_o  = pri_dest_i;
         reg_write_o = 1'b1;
      end

      late_out_o = (!reset_i && (count_q != 2'd0)) ? data_q[head_q] : '0;
      pending_o  = reset_i ? 2'd0 : count_q;
   end

   // FIFO bookkeeping and starvation counter next state.
   always_comb begin
      dest_d  = dest_q;
      data_d  = data_q;
      head_d  = head_q;
      count_d = count_q;
      wait_d  = wait_q;

      if (push) begin
         dest_d[tail] = late_dest_i;
         data_d[tail] = late_data_i;
      end
      if (late_grant) head_d = ~head_q;

      if (push && !late_grant) begin
         count_d = count_q + 2'd1;
      end else if (!push && late_grant) begin
         count_d = count_q - 2'd1;
      end

      if ((count_q == 2'd0) || late_grant) begin
         wait_d = 4'd0;
      end else if (wait_q != WAIT_MAX) begin
         wait_d = wait_q + 4'd1;
      end
   end

   // State registers with synchronous reset discarding any buffered results.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         dest_q  <= '0;
         data_q  <= '0;
         head_q  <= 1'b0;
         count_q <= 2'd0;
         wait_q  <= 4'd0;
      end else begin
         dest_q  <= dest_d;
         data_q  <= data_d;
         head_q  <= head_d;
         count_q <= count_d;
         wait_q  <= wait_d;
      end
   end

endmodule

// File: tb/tb_writeback_scheduler.sv
// tb/tb_writeback_scheduler.sv - self-checking bench for writeback_scheduler
module tb_writeback_scheduler;

   localparam int MAXW = 4;

   typedef struct packed {
      logic [2:0]  dest;
      logic [15:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        pv;
   logic [2:0]  ps;
   logic [2:0]  pd;
   logic        lv;
   logic        lready;
   logic [2:0]  ld;
   logic [15:0] ldata;
   logic [2:0]  sel;
   logic [15:0] lout;
   logic        rw;
   logic [2:0]  rdest;
   logic        stall;
   logic [1:0]  pend;

   logic [26:0] obs;
   assign obs = {sel, rdest, rw, stall, pend, lready, lout};

   int n_cmp = 0;
   int n_err = 0;

   ent_t mq[$];
   int   mwait;

   writeback_scheduler #(
      .DATA_WIDTH(16),
      .NREG_BITS (3),
      .MAX_WAIT  (MAXW)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .pri_valid_i (pv),
      .pri_sel_i   (ps),
      .pri_dest_i  (pd),
      .late_valid_i(lv),
      .late_ready_o(lready),
      .late_dest_i (ld),
      .late_data_i (ldata),
      .selection_o (sel),
      .late_out_o  (lout),
      .reg_write_o (rw),
      .reg_dest_o  (rdest),
      .stall_o     (stall),
      .pending_o   (pend)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pv = 1'b0; ps = 3'd0; pd = 3'd0;
      lv = 1'b0; ld = 3'd0; ldata = 16'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [26:0] e;
      reset = 1'b1;
      pv = 1'b1; ps = 3'd3; pd = 3'd4;
      lv = 1'b1; ld = 3'd2; ldata = 16'hBEEF;
      @(negedge clk);
      e = '0;
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL reset_idle: got %h want %h", obs, e); end
      tick();
      reset = 1'b0;
      idle_inputs();
      @(negedge clk);
      e = {3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL reset_after: got %h want %h", obs, e); end
      tick();
   endtask

   task automatic test_primary();
      logic [26:0] e;
      do_reset();
      pv = 1'b1; ps = 3'd2; pd = 3'd5;
      @(negedge clk);
      e = {3'd2, 3'd5, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL primary_grant: got %h want %h", obs, e); end
      tick();
      ps = 3'd7;
      @(negedge clk);
      e = {3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL primary_sel7: got %h want %h", obs, e); end
      tick();
   endtask

   task automatic test_late();
      logic [26:0] e;
      do_reset();
      lv = 1'b1; ld = 3'd3; ldata = 16'h1234;
      @(negedge clk);
      e = {3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL late_nobypass: got %h want %h", obs, e); end
      tick();
      lv = 1'b0;
      @(negedge clk);
      e = {3'd7, 3'd3, 1'b1, 1'b0, 2'd1, 1'b1, 16'h1234};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL late_write: got %h want %h", obs, e); end
      tick();
      @(negedge clk);
      e = {3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL late_drained: got %h want %h", obs, e); end
      tick();
   endtask

   task automatic test_full();
      logic [26:0] e;
      do_reset();
      pv = 1'b1; ps = 3'd1; pd = 3'd0;
      lv = 1'b1; ld = 3'd1; ldata = 16'hAAAA;
      @(negedge clk);
      e = {3'd1, 3'd0, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL full_push1: got %h want %h", obs, e); end
      tick();
      ld = 3'd2; ldata = 16'hBBBB;
      @(negedge clk);
      e = {3'd1, 3'd0, 1'b1, 1'b0, 2'd1, 1'b1, 16'hAAAA};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL full_push2: got %h want %h", obs, e); end
      tick();
      ld = 3'd4; ldata = 16'hCCCC;
      @(negedge clk);
      e = {3'd1, 3'd0, 1'b1, 1'b0, 2'd2, 1'b0, 16'hAAAA};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL full_notready: got %h want %h", obs, e); end
      tick();
      pv = 1'b0;
      @(negedge clk);
      e = {3'd7, 3'd1, 1'b1, 1'b0, 2'd2, 1'b0, 16'hAAAA};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL full_pop1: got %h want %h", obs, e); end
      tick();
      @(negedge clk);
      e = {3'd7, 3'd2, 1'b1, 1'b0, 2'd1, 1'b1, 16'hBBBB};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL full_pushpop: got %h want %h", obs, e); end
      tick();
      lv = 1'b0;
      @(negedge clk);
      e = {3'd7, 3'd4, 1'b1, 1'b0, 2'd1, 1'b1, 16'hCCCC};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL full_newhead: got %h want %h", obs, e); end
      tick();
      @(negedge clk);
      e = {3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL full_empty: got %h want %h", obs, e); end
      tick();
   endtask

   task automatic test_starvation();
      logic [26:0] e;
      do_reset();
      pv = 1'b1; ps = 3'd3; pd = 3'd2;
      lv = 1'b1; ld = 3'd1; ldata = 16'h5A5A;
      @(negedge clk);
      e = {3'd3, 3'd2, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL starve_push: got %h want %h", obs, e); end
      tick();
      lv = 1'b0;
      for (int i = 0; i < MAXW; i++) begin
         @(negedge clk);
         e = {3'd3, 3'd2, 1'b1, 1'b0, 2'd1, 1'b1, 16'h5A5A};
         n_cmp++; if (obs !== e) begin n_err++; $display("FAIL starve_pri%0d: got %h want %h", i, obs, e); end
         tick();
      end
      @(negedge clk);
      e = {3'd7, 3'd1, 1'b1, 1'b1, 2'd1, 1'b1, 16'h5A5A};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL starve_late: got %h want %h", obs, e); end
      tick();
      @(negedge clk);
      e = {3'd3, 3'd2, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL starve_resume: got %h want %h", obs, e); end
      tick();
   endtask

   task automatic test_hazard();
      logic [26:0] e;
      do_reset();
      pv = 1'b1; ps = 3'd4; pd = 3'd0;
      lv = 1'b1; ld = 3'd6; ldata = 16'h6666;
      @(negedge clk);
      e = {3'd4, 3'd0, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL hazard_push: got %h want %h", obs, e); end
      tick();
      lv = 1'b0; pd = 3'd6;
`ifdef WB_HAZARD_CHECK_EN
      @(negedge clk);
      e = {3'd7, 3'd6, 1'b1, 1'b1, 2'd1, 1'b1, 16'h6666};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL hazard_late_first: got %h want %h", obs, e); end
      tick();
      @(negedge clk);
      e = {3'd4, 3'd6, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL hazard_pri_next: got %h want %h", obs, e); end
      tick();
`else
      @(negedge clk);
      e = {3'd4, 3'd6, 1'b1, 1'b0, 2'd1, 1'b1, 16'h6666};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL hazard_pri_now: got %h want %h", obs, e); end
      tick();
      pv = 1'b0;
      @(negedge clk);
      e = {3'd7, 3'd6, 1'b1, 1'b0, 2'd1, 1'b1, 16'h6666};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL hazard_late_after: got %h want %h", obs, e); end
      tick();
`endif
   endtask

   task automatic test_reset_mid();
      logic [26:0] e;
      do_reset();
      pv = 1'b1; ps = 3'd1; pd = 3'd0;
      lv = 1'b1; ld = 3'd3; ldata = 16'h3333;
      tick();
      ld = 3'd5; ldata = 16'h5555;
      tick();
      lv = 1'b0;
      @(negedge clk);
      e = {3'd1, 3'd0, 1'b1, 1'b0, 2'd2, 1'b0, 16'h3333};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL rstmid_full: got %h want %h", obs, e); end
      tick();
      reset = 1'b1;
      @(negedge clk);
      e = '0;
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL rstmid_during: got %h want %h", obs, e); end
      tick();
      reset = 1'b0;
      pv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         e = {3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0};
         n_cmp++; if (obs !== e) begin n_err++; $display("FAIL rstmid_after%0d: got %h want %h", i, obs, e); end
         tick();
      end
   endtask

   task automatic test_random();
      logic [26:0] e;
      logic        pri_req, haz, lg, hold;
      logic [2:0]  e_sel, e_dest;
      logic        e_stall;
      logic [15:0] e_lout;
      ent_t        ent;
      do_reset();
      mq.delete();
      mwait = 0;
      hold  = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         reset = ($urandom_range(0, 49) == 0);
         if (!hold || reset) begin
            pv = ($urandom_range(0, 3) != 0);
            ps = 3'($urandom_range(0, 7));
            pd = 3'($urandom_range(0, 3));
         end
         lv    = $urandom_range(0, 1) == 1;
         ld    = 3'($urandom_range(0, 3));
         ldata = 16'($urandom);

         pri_req = pv && (ps != 3'd7);
         haz = 1'b0;
`ifdef WB_HAZARD_CHECK_EN
         foreach (mq[i]) if (pri_req && mq[i].dest == pd) haz = 1'b1;
`endif
         lg = (mq.size() > 0) && (!pri_req || mwait >= MAXW || haz);
         if (lg) begin
            e_sel = 3'd7; e_dest = mq[0].dest; e_stall = pri_req;
         end else if (pri_req) begin
            e_sel = ps; e_dest = pd; e_stall = 1'b0;
         end else begin
            e_sel = 3'd0; e_dest = 3'd0; e_stall = 1'b0;
         end
         e_lout = (mq.size() > 0) ? mq[0].data : 16'h0;
         if (reset) e = '0;
         else e = {e_sel, e_dest, (lg || pri_req), e_stall, 2'(mq.size()),
                   (mq.size() < 2), e_lout};

         @(negedge clk);
         n_cmp++; if (obs !== e) begin n_err++; $display("FAIL random_c%0d: got %h want %h", cyc, obs, e); end
         tick();

         if (reset) begin
            mq.delete();
            mwait = 0;
            hold  = 1'b0;
         end else begin
            if (lg) begin
               void'(mq.pop_front());
               mwait = 0;
            end else if (mq.size() > 0) begin
               mwait = (mwait < MAXW) ? mwait + 1 : MAXW;
            end else begin
               mwait = 0;
            end
            if (lv && (e[16] == 1'b1)) begin
               ent.dest = ld;
               ent.data = ldata;
               mq.push_back(ent);
            end
            hold = e_stall;
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_primary();
      test_late();
      test_full();
      test_starvation();
      test_hazard();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/writeback_scheduler.md
# writeback_scheduler

Sequencing controller for the register-file write port of the single-cycle CPU. Each cycle it chooses who writes the register file: the retiring instruction (primary) or a result from a long-latency unit (late path, e.g. a multi-cycle load). It drives the register-input-data mux select code, write enable and destination register. Late results are buffered in a 2-entry FIFO, with starvation protection and optional write-after-write ordering.

## Interface
- DATA_WIDTH, 16: width of late-path data.
- NREG_BITS, 3: register index width (8 registers).
- MAX_WAIT, 4: consecutive denied cycles after which the late head wins over the primary (1..15).

- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- PriValid  in  1  retiring instruction requests a register write this cycle.
- PriSel  in  3  mux select code for the primary write (0..6; 7 reserved).
- PriDest  in  NREG_BITS  primary destination register.
- LateValid  in  1  late unit offers a result.
- LateReady  out  1  FIFO accepts a result this cycle.
- LateDest  in  NREG_BITS  late destination register.
- LateData  in  DATA_WIDTH  late result.
- Selection  out  3  register-input-data mux select (7 = late path).
- LateOut  out  DATA_WIDTH  FIFO head data, wired to mux select-7 input.
- RegWrite  out  1  register-file write enable.
- RegDest  out  NREG_BITS  register-file write address.
- Stall  out  1  primary not accepted; CPU holds PC and instruction.
- Pending  out  2  FIFO occupancy (0..2).

## Operation
- FIFO: 2 entries of {dest, data}, plus registered count and head pointer.
  - Push when LateValid && LateReady.
  - LateReady = (count < 2) && !Reset.
  - No bypass: an entry is never granted in the cycle it is pushed.
- WaitCnt: increments when count > 0 and the head is not granted, saturating at MAX_WAIT. It clears on a late grant or when the FIFO is empty.
- Grant rules, combinational from registered state and current inputs, in priority order:
  1. Late grant when count > 0 and any of: !PriValid, PriSel == 7, WaitCnt == MAX_WAIT, or hazard (see Configuration).
     - Selection = 7, RegDest = head dest, RegWrite = 1, pop at clock edge.
     - Stall = PriValid && PriSel != 7.
  2. Else, if PriValid && PriSel != 7: primary grant.
     - Selection = PriSel, RegDest = PriDest, RegWrite = 1, Stall = 0.
  3. Else idle: Selection = 0, RegDest = 0, RegWrite = 0, Stall = 0.
- PriSel == 7 is illegal for the primary. It is treated as no request: never written, never stalled.
- LateOut always shows head data; it is 0 when the FIFO is empty.
- Push and pop in the same cycle with count == 1: count stays 1 and the pushed entry becomes the head.

## Timing
- Reset (synchronous) clears count, head pointer, WaitCnt and both entries to 0.
- While Reset is high: RegWrite = 0, Stall = 0, LateReady = 0, Selection = 0, RegDest = 0, LateOut = 0, Pending = 0.
- Reset mid-operation discards buffered entries. Their writes are lost, and the late unit must reissue them.
- Late latency: accepted at edge N, earliest write in cycle N+1.
- Primary latency: 0 cycles; the write commits at the same edge as the grant.
- A starved head is granted no later than MAX_WAIT+1 cycles after it becomes head.
- The CPU keeps PriValid/PriSel/PriDest stable while Stall = 1.

## Configuration
- WB_HAZARD_CHECK_EN defined:
  - Hazard = PriValid && PriSel != 7 && PriDest matches the dest of any valid FIFO entry.
  - A hazard forces late grants, oldest first, until no match remains, so the older write lands before the newer one.
- Undefined:
  - Hazard is always 0. Only the starvation rule orders writes.
  - Write-after-write ordering is software's responsibility.

## Test plan
- Reset, then primary only: PriValid = 1, PriSel = 2, PriDest = 5 → same cycle Selection = 2, RegDest = 5, RegWrite = 1, Stall = 0, Pending = 0.
- Late push of {dest 3, data 0x1234} with PriValid = 0 → next cycle Selection = 7, RegDest = 3, LateOut = 0x1234, RegWrite = 1; Pending goes 1 then 0.
- FIFO full (two pushes, PriValid held to keep it full with MAX_WAIT large) → LateReady = 0 and a third LateValid is not accepted. One pop with a simultaneous push keeps Pending = 1.
- Starvation, MAX_WAIT = 4: one entry queued, PriValid = 1 continuously with dest ≠ entry dest → 4 primary grants, then 1 late grant with Stall = 1, then primary resumes.
- Hazard: entry dest 6 queued, primary PriDest = 6 → with WB_HAZARD_CHECK_EN: late write first (Stall = 1), primary next cycle. Without it: primary writes immediately.
- Reset asserted with Pending = 2 and PriValid = 1 → outputs idle during Reset; Pending = 0 afterward and no late write ever occurs.
